// File: rtl/chip8_scanout.sv
// CHIP-8 framebuffer scanout: reads 64x32 VRAM words in raster order and emits a
// paced, back-pressurable pixel stream with coordinates and frame markers.
module chip8_scanout #(
  parameter int          WIDTH         = 64,
  parameter int          HEIGHT        = 32,
  parameter logic [31:0] ON_COLOR      = 32'hFFFFFFFF,
  parameter logic [31:0] OFF_COLOR     = 32'h00000000,
  parameter int          VBLANK_CYCLES = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_req_in,
  output logic                            vram_rd_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] vram_addr_out,
  input  logic [31:0]                     vram_data_in,
  output logic                            pix_valid_out,
  input  logic                            pix_ready_in,
  output logic [31:0]                     pix_data_out,
  output logic [$clog2(WIDTH)-1:0]        pix_x_out,
  output logic [$clog2(HEIGHT)-1:0]       pix_y_out,
  output logic                            sof_out,
  output logic                            eol_out,
  output logic                            eof_out,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [1:0]                      dbg_state_out
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int AW   = XW + YW;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int EW   = 32 + XW + YW + 3;

  // Pixel stream handshake: a pixel transfers on a rising edge where pix_valid_out and
  // pix_ready_in are both high; while valid is high and ready low, every pix_* and marker
  // output holds its value.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_VBLANK = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_rd_addr;
  logic          r_rd_done;
  logic          r_inflight;
  logic [AW-1:0] r_inflight_addr;
  logic [EW-1:0] r_fifo [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic [15:0]   r_vb_cnt;
  logic          r_frame_done;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_start;
  logic          w_last_xfer;
  logic          w_done_set;
  logic [2:0]    w_pending;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_entry;
  logic [XW-1:0] w_in_x;
  logic [YW-1:0] w_in_y;

  // Entry layout, LSB first: eof, eol, sof, y, x, color.
  assign w_head        = r_fifo[r_rd_ptr];
  assign pix_valid_out = (r_count != 2'd0);
  assign w_pop         = pix_valid_out & pix_ready_in;
  assign w_push        = r_inflight;
  assign w_last_xfer   = w_pop & w_head[0];
  assign w_start       = (r_state == ST_IDLE) & frame_req_in;

  // Counting this cycle's pop lets a read issue while the head drains, sustaining 1 pixel/clock.
  assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == ST_SCAN) & ~r_rd_done & (w_pending < 3'd2);

  assign w_in_x  = r_inflight_addr[XW-1:0];
  assign w_in_y  = r_inflight_addr[AW-1:XW];
  assign w_entry = {((|vram_data_in) ? ON_COLOR : OFF_COLOR), w_in_x, w_in_y,
                    (r_inflight_addr == '0), (&w_in_x), (&r_inflight_addr)};

  assign vram_rd_out    = w_issue;
  assign vram_addr_out  = r_rd_addr;
  assign pix_data_out   = pix_valid_out ? w_head[EW-1 -: 32]   : '0;
  assign pix_x_out      = pix_valid_out ? w_head[3+YW +: XW]   : '0;
  assign pix_y_out      = pix_valid_out ? w_head[3 +: YW]      : '0;
  assign sof_out        = pix_valid_out & w_head[2];
  assign eol_out        = pix_valid_out & w_head[1];
  assign eof_out        = pix_valid_out & w_head[0];
  assign busy_out       = (r_state != ST_IDLE);
  assign frame_done_out = r_frame_done;
  assign dbg_state_out  = r_state;

  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_req_in) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_last_xfer) begin
          if (VBLANK_CYCLES == 0) begin
            w_next_state = ST_IDLE;
            w_done_set   = 1'b1;
          end else begin
            w_next_state = ST_VBLANK;
          end
        end
      end
      ST_VBLANK: begin
        if (r_vb_cnt == 16'(VBLANK_CYCLES - 1)) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
      r_vb_cnt     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_frame_done <= w_done_set;
      r_vb_cnt     <= (r_state == ST_VBLANK) ? r_vb_cnt + 16'd1 : 16'd0;
    end
  end

  // The read address parks on the last word once it has been issued.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_addr       <= '0;
      r_rd_done       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_addr <= r_rd_addr;
      if (w_start) begin
        r_rd_addr <= '0;
        r_rd_done <= 1'b0;
      end else if (w_issue) begin
        if (r_rd_addr == AW'(NPIX - 1)) r_rd_done <= 1'b1;
        else                            r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_entry;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_scanout.sv
// Bench for chip8_scanout: VRAM model, randomized backpressure, expected-pixel queue
// built from raster-order arithmetic, plus frame timing checks on two VBLANK settings.
module tb_chip8_scanout;
  localparam int          W  = 64;
  localparam int          H  = 32;
  localparam int          N  = W * H;
  localparam int          VB = 16;
  localparam logic [31:0] ON_C  = 32'hFFFFFFFF;
  localparam logic [31:0] OFF_C = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_req, frame_req0;
  logic        vram_rd, vram_rd0;
  logic [10:0] vram_addr, vram_addr0;
  logic [31:0] vram_data, vram_data0;
  logic        pix_valid, pix_valid0, pix_ready, pix_ready0;
  logic [31:0] pix_data, pix_data0;
  logic [5:0]  pix_x, pix_x0;
  logic [4:0]  pix_y, pix_y0;
  logic        sof, eol, eof, busy, frame_done;
  logic        sof0, eol0, eof0, busy0, frame_done0;
  logic [1:0]  dbg_state, dbg_state0;

  logic [31:0] vram [N];
  logic [45:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;

  int n_xfer, n_reads, n_done, last_xfer_cyc, first_rd_cyc, first_valid_cyc, done_cyc, req_cyc;
  int on_cnt, on_x, on_y;
  logic        prev_stall;
  logic [45:0] prev_out, mon_cur;

  int xfer0 = 0, last0 = 0, n_done0 = 0, done0_cyc = 0, last0_at_done = 0, xfer0_at_done = 0;
  int first_rd0 = -1, rd0_cyc = 0, req0_cyc = 0;
  logic       got_rd0 = 1'b0;
  logic [10:0] rd0_addr = '0;

  chip8_scanout #(.VBLANK_CYCLES(VB)) dut (
    .clk_in(clk), .rst_in(rst), .frame_req_in(frame_req),
    .vram_rd_out(vram_rd), .vram_addr_out(vram_addr), .vram_data_in(vram_data),
    .pix_valid_out(pix_valid), .pix_ready_in(pix_ready), .pix_data_out(pix_data),
    .pix_x_out(pix_x), .pix_y_out(pix_y), .sof_out(sof), .eol_out(eol), .eof_out(eof),
    .busy_out(busy), .frame_done_out(frame_done), .dbg_state_out(dbg_state)
  );

  chip8_scanout #(.VBLANK_CYCLES(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .frame_req_in(frame_req0),
    .vram_rd_out(vram_rd0), .vram_addr_out(vram_addr0), .vram_data_in(vram_data0),
    .pix_valid_out(pix_valid0), .pix_ready_in(pix_ready0), .pix_data_out(pix_data0),
    .pix_x_out(pix_x0), .pix_y_out(pix_y0), .sof_out(sof0), .eol_out(eol0), .eof_out(eof0),
    .busy_out(busy0), .frame_done_out(frame_done0), .dbg_state_out(dbg_state0)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Synchronous-read VRAM; garbage outside read cycles exposes mistimed captures.
  always @(posedge clk) begin
    vram_data  <= vram_rd  ? vram[vram_addr]  : $urandom;
    vram_data0 <= vram_rd0 ? vram[vram_addr0] : $urandom;
  end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 9) < 3);
      default: pix_ready = 1'b0;
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  task automatic sb_clear();
    exp_q.delete();
    n_xfer = 0; n_reads = 0; n_done = 0; on_cnt = 0; on_x = -1; on_y = -1;
    first_rd_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic load_expected();
    logic [31:0] col;
    for (int a = 0; a < N; a++) begin
      col = (vram[a] != 32'h0) ? ON_C : OFF_C;
      exp_q.push_back({col, 6'(a % W), 5'(a / W), (a == 0), ((a % W) == W - 1), (a == N - 1)});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_cur = {pix_data, pix_x, pix_y, sof, eol, eof};
      if (prev_stall) check("stall_hold", {pix_valid, mon_cur}, {1'b1, prev_out});
      if (vram_rd) begin
        check("rd_addr", vram_addr, n_reads);
        check("rd_bound", ((n_reads - n_xfer - ((pix_valid && pix_ready) ? 1 : 0)) < 2), 1);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        n_reads++;
      end
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pix_valid && pix_ready) begin
        check("q_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pixel", mon_cur, exp_q.pop_front());
        if (pix_data == ON_C) begin on_cnt++; on_x = pix_x; on_y = pix_y; end
        n_xfer++;
        last_xfer_cyc = cyc;
      end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = mon_cur;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid0 && pix_ready0) begin xfer0++; last0 = cyc; end
      if (frame_done0) begin
        if (n_done0 == 0) begin done0_cyc = cyc; last0_at_done = last0; xfer0_at_done = xfer0; end
        n_done0++;
      end
      if (vram_rd0) begin
        if (first_rd0 < 0) first_rd0 = cyc;
        if (n_done0 == 1 && !got_rd0) begin got_rd0 = 1'b1; rd0_cyc = cyc; rd0_addr = vram_addr0; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_vram(input int mode);
    for (int a = 0; a < N; a++) begin
      case (mode)
        0:       vram[a] = 32'h0;
        1:       vram[a] = (a == 65) ? 32'hFFFFFFFF : 32'h0;
        default: vram[a] = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      endcase
    end
  endtask

  task automatic start_frame();
    sb_clear();
    load_expected();
    @(posedge clk); #1;
    frame_req = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
    check("done_timeout", (n_done != 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame_end_checks();
    check("xfer_count", n_xfer, N);
    check("sb_empty", exp_q.size(), 0);
    check("done_delay", done_cyc - last_xfer_cyc, VB + 1);
    check("done_pulses", n_done, 1);
    check("busy_after", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; frame_req = 1'b0; frame_req0 = 1'b0; pix_ready = 1'b1; pix_ready0 = 1'b1;
    fill_vram(0);
    sb_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {vram_rd, vram_addr, pix_valid, pix_data, pix_x, pix_y,
                         sof, eol, eof, busy, frame_done}, 0);
    check("reset_state", {dbg_state, dbg_state0, busy0, pix_valid0, vram_rd0}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Blank screen, full rate, with a request pulse mid-scan that must be ignored.
    start_frame();
    repeat (500) @(posedge clk);
    #1;
    check("busy_scan", busy, 1);
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    wait_done(3000);
    check("first_rd_lat", first_rd_cyc - req_cyc, 1);
    check("first_valid_lat", first_valid_cyc - req_cyc, 3);
    check("frame_len", last_xfer_cyc - req_cyc, N + 2);
    frame_end_checks();
    repeat (10) @(posedge clk);
    #1;
    check("no_restart_reads", n_reads, N);
    check("no_restart_busy", busy, 0);

    // Single lit pixel at (1,1).
    fill_vram(1);
    start_frame();
    wait_done(3000);
    frame_end_checks();
    check("on_count", on_cnt, 1);
    check("on_xy", {on_x, on_y}, {32'd1, 32'd1});

    // Random image under ~30% ready duty.
    fill_vram(2);
    ready_mode = 1;
    start_frame();
    wait_done(20000);
    frame_end_checks();
    ready_mode = 0;

    // Sink stalled for 20 cycles from the start, then released.
    fill_vram(2);
    ready_mode = 2;
    start_frame();
    repeat (20) @(posedge clk);
    #1;
    check("stall_reads", n_reads, 2);
    check("stall_valid", pix_valid, 1);
    ready_mode = 0;
    wait_done(3000);
    frame_end_checks();

    // Asynchronous reset at pixel 700, then a clean restart.
    fill_vram(2);
    start_frame();
    for (int i = 0; i < 3000 && n_xfer < 700; i++) @(posedge clk);
    check("reach_700", (n_xfer >= 700), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outs", {vram_rd, vram_addr, pix_valid, pix_data, pix_x, pix_y,
                               sof, eol, eof, busy, frame_done, dbg_state}, 0);
    sb_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_reset", {pix_valid, busy, vram_rd}, 0);
    check("no_reads_after_reset", n_reads, 0);
    start_frame();
    wait_done(3000);
    check("restart_first_rd", first_rd_cyc - req_cyc, 1);
    frame_end_checks();

    // VBLANK_CYCLES=0 instance with the request held high: back-to-back frames.
    fill_vram(2);
    @(posedge clk); #1;
    frame_req0 = 1'b1;
    req0_cyc = cyc;
    for (int i = 0; i < 3000 && n_done0 == 0; i++) @(posedge clk);
    check("v0_done_timeout", (n_done0 != 0), 1);
    for (int i = 0; i < 10 && !got_rd0; i++) @(posedge clk);
    check("v0_second_rd_seen", got_rd0, 1);
    #1;
    frame_req0 = 1'b0;
    for (int i = 0; i < 3000 && n_done0 < 2; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("v0_first_rd_lat", first_rd0 - req0_cyc, 1);
    check("v0_frame1_xfers", xfer0_at_done, N);
    check("v0_done_delay", done0_cyc - last0_at_done, 1);
    check("v0_restart_rd", rd0_cyc - done0_cyc, 1);
    check("v0_restart_addr", rd0_addr, 0);
    check("v0_two_frames", {n_done0, xfer0}, {32'd2, 32'(2 * N)});
    check("v0_busy_end", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
